fsk_tx: RTL and testbench

FSK_TX -- requirements
Module: fsk_tx

---
 rtl/fsk_tx.sv | 146 ++++++++++++++
 tb/tb_fsk_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fsk_tx.sv
// fsk_tx: phase-reset 2-FSK serialiser, MSB first; first symbol starts the cycle after acceptance, done pulses the cycle after the final bit.
// Backpressure: in_ready only in IDLE or the last cycle of the last bit. FSK_TX_PREAMBLE_EN prepends PRE_BITS alternating symbols.
module fsk_tx #(
    parameter int FRAME_W  = 16,
    parameter int SYM_CYC  = 16,
    parameter int DIV_HI   = 1,
    parameter int DIV_LO   = 2,
    parameter int PRE_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               fsk_out,
    output logic               busy,
    output logic               done
);

    localparam int SYM_W  = $clog2(SYM_CYC);
    localparam int TONE_W = $clog2(DIV_LO);
    localparam int MAXB   = (FRAME_W > PRE_BITS) ? FRAME_W : PRE_BITS;
    localparam int BIT_W  = $clog2(MAXB);

    localparam logic [SYM_W-1:0]  SYM_LAST   = SYM_W'(SYM_CYC - 1);
    localparam logic [BIT_W-1:0]  FRAME_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [TONE_W-1:0] HI_LAST    = TONE_W'(DIV_HI - 1);
    localparam logic [TONE_W-1:0] LO_LAST    = TONE_W'(DIV_LO - 1);

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    state_t             state_q, state_d;
    logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TONE_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic               tone_q, tone_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               done_q, done_d;

    logic               sym_wrap, last_bit, accept, cur_bit;
    logic [TONE_W-1:0]  tone_last;
    state_t             start_st;

    always_comb begin
        sym_wrap  = (state_q != IDLE) && (sym_cnt_q == SYM_LAST);
        last_bit  = (state_q == DATA) && (bit_cnt_q == FRAME_LAST);
        in_ready  = rst && ((state_q == IDLE) || (last_bit && sym_wrap));
        accept    = in_valid && in_ready;
`ifdef FSK_TX_PREAMBLE_EN
        start_st  = PRE;
        cur_bit   = (state_q == PRE) ? ~bit_cnt_q[0] : shift_q[FRAME_W-1];
`else
        start_st  = DATA;
        cur_bit   = shift_q[FRAME_W-1];
`endif
        tone_last = cur_bit ? HI_LAST : LO_LAST;

        state_d   = state_q;
        sym_cnt_d = sym_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done_d    = last_bit && sym_wrap;
        if (tone_cnt_q == tone_last) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
        end else begin
            tone_cnt_d = tone_cnt_q + 1'b1;
            tone_d     = tone_q;
        end

        case (state_q)
            IDLE: begin
                sym_cnt_d  = '0;
                tone_cnt_d = '0;
                tone_d     = 1'b0;
                if (accept) begin
                    state_d   = start_st;
                    shift_d   = in_data;
                    bit_cnt_d = '0;
                end
            end
`ifdef FSK_TX_PREAMBLE_EN
            PRE: begin
                if (sym_wrap) begin
                    if (bit_cnt_q == BIT_W'(PRE_BITS - 1)) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`endif
            DATA: begin
                if (sym_wrap) begin
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        // Back-to-back frame starts with no gap symbol
                        if (accept) begin
                            state_d = start_st;
                            shift_d = in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Phase reset: every symbol begins with tone low
        if (sym_wrap) begin
            sym_cnt_d  = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            sym_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            shift_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
        end
    end

    assign fsk_out = tone_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_fsk_tx.sv
// Directed bench for fsk_tx: default instance plus an 8-bit/24-cycle instance, per-symbol waveform checks.
module tb_fsk_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FSK_TX_PREAMBLE_EN
    localparam int PRE = 8;
`else
    localparam int PRE = 0;
`endif

    logic        rst;
    logic [15:0] din;
    logic        vld_a, vld_b;
    logic        rdy_a, fsk_a, busy_a, done_a;
    logic        rdy_b, fsk_b, busy_b, done_b;
    logic        sel;
    int          checks   = 0;
    int          failures = 0;

    fsk_tx dut_a (
        .clk(clk), .rst(rst), .in_data(din), .in_valid(vld_a),
        .in_ready(rdy_a), .fsk_out(fsk_a), .busy(busy_a), .done(done_a)
    );

    fsk_tx #(.FRAME_W(8), .SYM_CYC(24), .DIV_HI(3), .DIV_LO(6)) dut_b (
        .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(vld_b),
        .in_ready(rdy_b), .fsk_out(fsk_b), .busy(busy_b), .done(done_b)
    );

    wire o_fsk  = sel ? fsk_b  : fsk_a;
    wire o_busy = sel ? busy_b : busy_a;
    wire o_done = sel ? done_b : done_a;
    wire o_rdy  = sel ? rdy_b  : rdy_a;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        din = d;
        if (sel) vld_b = v;
        else     vld_a = v;
    endtask

    task automatic accept(input logic [15:0] d);
        chk("rdy_idle", 32'(o_rdy), 32'd1);
        drive(1'b1, d);
        @(negedge clk);
    endtask

    // Entered observing cycle 0 of the first symbol; leaves observing the cycle after the last one.
    task automatic body(input logic [15:0] d, input logic [15:0] nxt, input bit chain);
        int fw, sym, dhi, dlo, nsym, dv, busy_n, done_n, rdy_err;
        logic [31:0] wav, exp;
        bit b, last;
        fw  = sel ? 8 : 16;
        sym = sel ? 24 : 16;
        dhi = sel ? 3 : 1;
        dlo = sel ? 6 : 2;
        nsym = PRE + fw;
        busy_n = 0; done_n = 0; rdy_err = 0;
        drive(chain, nxt);
        for (int s = 0; s < nsym; s++) begin
            wav = '0;
            exp = '0;
            b  = (s < PRE) ? (s % 2 == 0) : d[fw-1-(s-PRE)];
            dv = b ? dhi : dlo;
            for (int c = 0; c < sym; c++) begin
                wav[c] = o_fsk;
                exp[c] = ((c / dv) % 2) == 1;
                busy_n += int'(o_busy);
                if (s > 0 || c > 0) done_n += int'(o_done);
                last = (s == nsym - 1) && (c == sym - 1);
                if (o_rdy !== last) rdy_err++;
                @(negedge clk);
            end
            chk($sformatf("wav_s%0d", s), wav, exp);
        end
        chk("busy_cycles", 32'(busy_n), 32'(nsym * sym));
        chk("done_mid", 32'(done_n), 32'd0);
        chk("rdy_gate", 32'(rdy_err), 32'd0);
    endtask

    initial begin
        int dn;
        rst = 1'b0; vld_a = 1'b0; vld_b = 1'b0; din = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_fsk",  32'(o_fsk),  32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_rdy",  32'(o_rdy),  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single frame, data changed after acceptance
        accept(16'hA5F0);
        body(16'hA5F0, 16'h1234, 1'b0);
        chk("done_pulse", 32'(o_done), 32'd1);
        chk("busy_end",   32'(o_busy), 32'd0);
        chk("rdy_back",   32'(o_rdy),  32'd1);
        @(negedge clk);
        chk("done_once",  32'(o_done), 32'd0);

        // Back-to-back with valid held high
        accept(16'hFFFF);
        body(16'hFFFF, 16'h0000, 1'b1);
        chk("done_b2b1", 32'(o_done), 32'd1);
        chk("no_gap",    32'(o_busy), 32'd1);
        body(16'h0000, 16'hBEEF, 1'b0);
        chk("done_b2b2", 32'(o_done), 32'd1);
        chk("busy_b2b",  32'(o_busy), 32'd0);
        @(negedge clk);

        // Reset mid-frame at cycle 100
        accept(16'h3C3C);
        drive(1'b0, 16'h0000);
        dn = 0;
        repeat (100) begin
            dn += int'(o_done);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_fsk",  32'(o_fsk),  32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(32'(dn) + 32'(o_done)), 32'd0);
        chk("abort_rdy",  32'(o_rdy),  32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 32'(o_done), 32'd0);
        accept(16'h8001);
        body(16'h8001, 16'h7FFE, 1'b0);
        chk("done_post_rst", 32'(o_done), 32'd1);
        @(negedge clk);

`ifdef FSK_TX_PREAMBLE_EN
        accept(16'h0001);
        body(16'h0001, 16'hFFFF, 1'b0);
        chk("done_pre", 32'(o_done), 32'd1);
        @(negedge clk);
`endif

        // Alternate parameter set
        sel = 1'b1;
        @(negedge clk);
        accept(16'h0081);
        body(16'h0081, 16'h007E, 1'b0);
        chk("done_b",  32'(o_done), 32'd1);
        chk("busy_b",  32'(o_busy), 32'd0);
        chk("idle_a",  32'(busy_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
